// File: rtl/display_scroll_controller.sv
// Message buffer for a 4-digit seven-segment window: shows the newest four entries
// or scrolls through the whole buffer, and reports a timed "loaded" mode on State.
module display_scroll_controller #(
  parameter int DEPTH      = 16,
  parameter int SCROLL_DIV = 25_000_000,
  parameter int ACK_CYCLES = 50_000_000
) (
  input  logic                   clock_100Mhz,
  input  logic                   reset,
  input  logic [7:0]             char_in,
  input  logic                   char_valid,
  input  logic                   clear,
  input  logic                   scroll_en,
  input  logic                   edit_active,
  output logic [31:0]            characters,
  output logic [2:0]             State,
  output logic [7:0]             loadedChar,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int TW = $clog2(ACK_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    SCROLL = 2'd2
  } mode_e;

  logic [7:0]    mem_q [DEPTH];

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] start_q, start_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] ack_q, ack_d;
  mode_e         mode_q, mode_d;
  logic [31:0]   characters_q, characters_d;
  logic [2:0]    state_q, state_d;
  logic [7:0]    loaded_q, loaded_d;
  logic          overflow_q, overflow_d;

  logic          accept;
  logic          drop;
  logic [CW-1:0] start_inc;
  logic [CW:0]   show_idx;
  logic [CW:0]   scroll_idx;
  logic [7:0]    digit;

  assign full = (count_q == CW'(DEPTH));

  // Buffer bookkeeping, mode selection, scroll stepping and the ack timer.
  always_comb begin
    accept     = char_valid && !clear && !full;
    drop       = char_valid && !clear && full;
    count_d    = count_q;
    loaded_d   = loaded_q;
    overflow_d = drop;
    presc_d    = '0;
    start_d    = '0;
    start_inc  = {1'b0, start_q} + CW'(1);

    if (clear) begin
      count_d = '0;
    end else if (accept) begin
      count_d  = count_q + CW'(1);
      loaded_d = char_in;
    end

    if (count_d == '0) begin
      mode_d = IDLE;
    end else if (scroll_en && (32'(count_d) > 32'd4)) begin
      mode_d = SCROLL;
    end else begin
      mode_d = SHOW;
    end

    // The wrap point uses the count seen before this edge, so a write only
    // lengthens the loop from the following step onward.
    if (mode_q == SCROLL && mode_d == SCROLL) begin
      if (presc_q == PW'(SCROLL_DIV - 1)) begin
        presc_d = '0;
        start_d = (start_inc >= count_q) ? '0 : start_q + AW'(1);
      end else begin
        presc_d = presc_q + PW'(1);
        start_d = start_q;
      end
    end

    if (accept) begin
      ack_d = TW'(ACK_CYCLES);
    end else if (ack_q != '0) begin
      ack_d = ack_q - TW'(1);
    end else begin
      ack_d = ack_q;
    end

    if (ack_d != '0) begin
      state_d = 3'b111;
    end else if (edit_active) begin
      state_d = 3'b110;
    end else begin
      state_d = 3'b000;
    end
  end

  // Display window built from last cycle's buffer, count and start.
  always_comb begin
    characters_d = '1;
    show_idx     = '0;
    scroll_idx   = '0;
    digit        = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      digit      = 8'hFF;
      show_idx   = {1'b0, count_q} + (CW+1)'(i);
      scroll_idx = {2'b00, start_q} + (CW+1)'(i);
      if (scroll_idx >= {1'b0, count_q}) begin
        scroll_idx = scroll_idx - {1'b0, count_q};
      end
      case (mode_q)
        SHOW: begin
          if (show_idx >= (CW+1)'(4)) begin
            digit = mem_q[AW'(show_idx - (CW+1)'(4))];
          end
        end
        SCROLL:  digit = mem_q[AW'(scroll_idx)];
        default: digit = 8'hFF;
      endcase
      characters_d[31 - 8*i -: 8] = digit;
    end
  end

  always_ff @(posedge clock_100Mhz) begin
    if (accept) begin
      mem_q[AW'(count_q)] <= char_in;
    end
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      count_q      <= '0;
      start_q      <= '0;
      presc_q      <= '0;
      ack_q        <= '0;
      mode_q       <= IDLE;
      characters_q <= 32'hFFFF_FFFF;
      state_q      <= 3'b000;
      loaded_q     <= 8'hFF;
      overflow_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      start_q      <= start_d;
      presc_q      <= presc_d;
      ack_q        <= ack_d;
      mode_q       <= mode_d;
      characters_q <= characters_d;
      state_q      <= state_d;
      loaded_q     <= loaded_d;
      overflow_q   <= overflow_d;
    end
  end

  assign characters = characters_q;
  assign State      = state_q;
  assign loadedChar = loaded_q;
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_display_scroll_controller.sv
// Bench for display_scroll_controller: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the display behaviour.
module tb_display_scroll_controller;

  localparam int DEPTH      = 16;
  localparam int SCROLL_DIV = 4;
  localparam int ACK_CYCLES = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        clear;
  logic        scroll_en;
  logic        edit_active;
  logic [31:0] characters;
  logic [2:0]  State;
  logic [7:0]  loadedChar;
  logic [4:0]  count;
  logic        full;
  logic        overflow;

  always #5 clk = ~clk;

  display_scroll_controller #(
    .DEPTH(DEPTH),
    .SCROLL_DIV(SCROLL_DIV),
    .ACK_CYCLES(ACK_CYCLES)
  ) dut (
    .clock_100Mhz(clk),
    .reset(reset),
    .char_in(char_in),
    .char_valid(char_valid),
    .clear(clear),
    .scroll_en(scroll_en),
    .edit_active(edit_active),
    .characters(characters),
    .State(State),
    .loadedChar(loadedChar),
    .count(count),
    .full(full),
    .overflow(overflow)
  );

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0]  m_buf[$];
  int          m_start = 0;
  int          m_presc = 0;
  int          m_ack   = 0;
  int          m_mode  = 0;
  logic [31:0] m_chars = '1;
  logic [2:0]  m_state = 3'b000;
  logic [7:0]  m_loaded = 8'hFF;
  logic        m_ovf = 1'b0;

  // Mode codes in the model: 0 blank, 1 newest-four, 2 scrolling.
  function automatic int mode_of(int n, logic en);
    if (n == 0) return 0;
    if (n > 4 && en) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] view(int mode, int start);
    logic [31:0] v;
    int n;
    v = '1;
    n = m_buf.size();
    for (int i = 0; i < 4; i++) begin
      if (mode == 1) begin
        if (n - 4 + i >= 0) v[31 - 8*i -: 8] = m_buf[n - 4 + i];
      end else if (mode == 2) begin
        v[31 - 8*i -: 8] = m_buf[(start + i) % n];
      end
    end
    return v;
  endfunction

  task automatic model_edge();
    int n;
    int nm;
    logic accepted;
    logic [31:0] nc;
    n = m_buf.size();
    if (reset) begin
      m_buf.delete();
      m_start  = 0;
      m_presc  = 0;
      m_ack    = 0;
      m_mode   = 0;
      m_chars  = 32'hFFFF_FFFF;
      m_state  = 3'b000;
      m_loaded = 8'hFF;
      m_ovf    = 1'b0;
      return;
    end
    nc       = view(m_mode, m_start);
    m_ovf    = char_valid && !clear && (n == DEPTH);
    accepted = char_valid && !clear && (n < DEPTH);
    if (clear) begin
      m_buf.delete();
    end else if (accepted) begin
      m_buf.push_back(char_in);
      m_loaded = char_in;
    end
    if (accepted) m_ack = ACK_CYCLES;
    else if (m_ack > 0) m_ack--;
    nm = mode_of(m_buf.size(), scroll_en);
    if (nm == 2 && m_mode == 2) begin
      if (m_presc == SCROLL_DIV - 1) begin
        m_presc = 0;
        m_start = (m_start + 1) % n;
      end else begin
        m_presc++;
      end
    end else begin
      m_presc = 0;
      m_start = 0;
    end
    m_state = (m_ack != 0) ? 3'b111 : (edit_active ? 3'b110 : 3'b000);
    m_mode  = nm;
    m_chars = nc;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check("characters", characters, m_chars);
    check("State", {29'b0, State}, {29'b0, m_state});
    check("loadedChar", {24'b0, loadedChar}, {24'b0, m_loaded});
    check("count", {27'b0, count}, 32'(m_buf.size()));
    check("full", {31'b0, full}, {31'b0, (m_buf.size() == DEPTH)});
    check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
  endtask

  task automatic apply_stimulus(input logic rst, input logic cv, input logic [7:0] ch,
                                input logic clr, input logic en, input logic ed);
    reset       = rst;
    char_valid  = cv;
    char_in     = ch;
    clear       = clr;
    scroll_en   = en;
    edit_active = ed;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_output();
  endtask

  task automatic idle(input int cycles, input logic en, input logic ed);
    for (int k = 0; k < cycles; k++) apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0, en, ed);
  endtask

  task automatic write(input logic [7:0] ch, input logic en, input logic ed);
    apply_stimulus(1'b0, 1'b1, ch, 1'b0, en, ed);
  endtask

  task automatic do_clear();
    apply_stimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] last_fill;
    logic rst, cv, clr, en, ed;

    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("rst_chars", characters, 32'hFFFF_FFFF);
    check("rst_loaded", {24'b0, loadedChar}, 32'h0000_00FF);

    // Two writes shown right-aligned with blanks on the left.
    write(8'hC0, 1'b0, 1'b0);
    write(8'hF9, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    check("show_two_chars", characters, 32'hFFFF_C0F9);
    check("show_two_count", {27'b0, count}, 32'd2);
    check("show_two_loaded", {24'b0, loadedChar}, 32'h0000_00F9);

    // Six entries with scrolling enabled, then a full rotation.
    do_clear();
    for (int k = 0; k < 6; k++) write(8'hA0 + 8'(k), 1'b1, 1'b0);
    check("scroll_first_window", characters, 32'hA0A1_A2A3);
    idle(30, 1'b1, 1'b0);

    // Clear beats a simultaneous write while scrolling.
    apply_stimulus(1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1, 1'b0);
    check("clear_chars", characters, 32'hFFFF_FFFF);
    check("clear_count", {27'b0, count}, 32'd0);
    check("clear_no_overflow", {31'b0, overflow}, 32'd0);

    // Fill to capacity, then one dropped write.
    last_fill = 8'h00;
    for (int k = 0; k < DEPTH; k++) begin
      last_fill = 8'($urandom);
      write(last_fill, 1'b0, 1'b0);
    end
    write(8'h77, 1'b0, 1'b0);
    check("full_overflow_pulse", {31'b0, overflow}, 32'd1);
    check("full_count", {27'b0, count}, 32'd16);
    check("full_flag", {31'b0, full}, 32'd1);
    check("full_loaded_kept", {24'b0, loadedChar}, {24'b0, last_fill});
    idle(1, 1'b0, 1'b0);
    check("overflow_one_cycle", {31'b0, overflow}, 32'd0);

    // Ack indication dominates edit indication until the timer expires.
    do_clear();
    write(8'h92, 1'b0, 1'b1);
    check("ack_state", {29'b0, State}, 32'd7);
    idle(3, 1'b0, 1'b1);
    check("edit_state", {29'b0, State}, 32'd6);
    idle(2, 1'b0, 1'b0);
    check("plain_state", {29'b0, State}, 32'd0);

    // Reset in the middle of scrolling, then a fresh write.
    do_clear();
    for (int k = 0; k < 6; k++) write(8'h10 + 8'(k), 1'b1, 1'b0);
    idle(7, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 8'h99, 1'b0, 1'b1, 1'b1);
    check("midscroll_rst_chars", characters, 32'hFFFF_FFFF);
    check("midscroll_rst_state", {29'b0, State}, 32'd0);
    check("midscroll_rst_loaded", {24'b0, loadedChar}, 32'h0000_00FF);
    check("midscroll_rst_count", {27'b0, count}, 32'd0);
    write(8'h3C, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    check("post_rst_write", characters, 32'hFFFF_FF3C);

    // Random traffic.
    en = 1'b1;
    ed = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 149) == 0);
      clr = ($urandom_range(0, 59) == 0);
      cv  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) en = ~en;
      if ($urandom_range(0, 19) == 0) ed = ~ed;
      apply_stimulus(rst, cv, 8'($urandom), clr, en, ed);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
